hssi_axis_pkt_monitor: RTL and testbench

- Passive per-packet monitor on one HSSI AXI-Stream channel (TX or RX); sits directly upstream of the HSSI transaction logger.
- Taps valid/ready/data/keep/last/user without driving the bus, assembles a per-packet summary record and queues it in a small FIFO.
- Records are presented on a valid/ready interface; the logger consumes them and formats its text lines from the record fields.

---
 rtl/hssi_axis_pkt_monitor.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_hssi_axis_pkt_monitor.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssi_axis_pkt_monitor.sv
// Passive per-packet monitor for one HSSI AXI-Stream channel.
// Watches the tapped handshake, accumulates byte/beat counts, timestamps and
// protocol flags per packet, and queues one summary record per packet in a
// small FIFO that the transaction logger drains over a valid/ready port.
module hssi_axis_pkt_monitor #(
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int LEN_W      = 16,
    parameter int TS_W       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic              clk,
    input  logic              SoftReset_n,
    input  logic              mon_tvalid,
    input  logic              mon_tready,
    input  logic [DATA_W-1:0] mon_tdata,
    input  logic [KEEP_W-1:0] mon_tkeep,
    input  logic              mon_tlast,
    input  logic              mon_tuser,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [LEN_W-1:0]  rec_bytes,
    output logic [LEN_W-1:0]  rec_beats,
    output logic [TS_W-1:0]   rec_sop_ts,
    output logic [TS_W-1:0]   rec_eop_ts,
    output logic [3:0]        rec_flags,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [TS_W-1:0]   cyc_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam int FLG_USER  = 0;
    localparam int FLG_STALL = 1;
    localparam int FLG_SAT   = 2;
    localparam int FLG_KEEP  = 3;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] bytes;
        logic [LEN_W-1:0] beats;
        logic [TS_W-1:0]  sop_ts;
        logic [TS_W-1:0]  eop_ts;
        logic [3:0]       flags;
    } rec_t;

    // Number of valid byte lanes in a beat (KEEP_W must fit in LEN_W bits).
    function automatic logic [LEN_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [LEN_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            c = c + LEN_W'(k[i]);
        end
        return c;
    endfunction

    // Saturating add; the top bit of the result reports that saturation hit.
    function automatic logic [LEN_W:0] sat_add(input logic [LEN_W-1:0] a,
                                              input logic [LEN_W-1:0] b);
        logic [LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[LEN_W]) begin
            s = {1'b1, {LEN_W{1'b1}}};
        end
        return s;
    endfunction

    // Non-last beats must be full; the last beat must be a non-empty run of
    // ones starting at lane 0 (k+1 is then a power of two, or wraps to 0).
    function automatic logic keep_illegal(input logic [KEEP_W-1:0] k,
                                          input logic             last);
        if (!last) begin
            return k != '1;
        end
        return (k == '0) || ((k & (k + KEEP_W'(1))) != '0);
    endfunction

    // Registers
    state_t             state_q, state_d;
    logic [TS_W-1:0]    cyc_q, cyc_d;
    logic [LEN_W-1:0]   bytes_q, bytes_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [TS_W-1:0]    sop_ts_q, sop_ts_d;
    logic [3:0]         flags_q, flags_d;
    logic               pend_viol_q, pend_viol_d;
    logic               stall_q, stall_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic [KEEP_W-1:0]  hold_keep_q, hold_keep_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_user_q, hold_user_d;
    logic               stg_valid_q, stg_valid_d;
    rec_t               stg_rec_q, stg_rec_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    rec_t               mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic               beat;
    logic               viol;
    logic [LEN_W-1:0]   keep_cnt;
    logic               keep_err;
    logic [LEN_W:0]     byte_sum;
    logic [LEN_W:0]     beat_sum;
    logic [3:0]         flags_nxt;
    logic               fifo_full;
    logic               fifo_pop;
    logic               fifo_push;
    logic               fifo_drop;
    rec_t               head;

    // Observe the stream: beats, lane counts and the held-word stability check.
    always_comb begin
        beat        = mon_tvalid & mon_tready;
        keep_cnt    = popcount(mon_tkeep);
        keep_err    = keep_illegal(mon_tkeep, mon_tlast);
        // A word offered but not taken last cycle must still be offered, unchanged.
        viol        = stall_q & (!mon_tvalid
                                 || (mon_tdata != hold_data_q)
                                 || (mon_tkeep != hold_keep_q)
                                 || (mon_tlast != hold_last_q)
                                 || (mon_tuser != hold_user_q));
        stall_d     = mon_tvalid & ~mon_tready;
        hold_data_d = mon_tdata;
        hold_keep_d = mon_tkeep;
        hold_last_d = mon_tlast;
        hold_user_d = mon_tuser;
        cyc_d       = cyc_q + TS_W'(1);
    end

    // Packet FSM: accumulate per-packet fields and stage the finished record.
    always_comb begin
        state_d     = state_q;
        bytes_d     = bytes_q;
        beats_d     = beats_q;
        sop_ts_d    = sop_ts_q;
        flags_d     = flags_q;
        pend_viol_d = pend_viol_q;
        stg_valid_d = 1'b0;
        stg_rec_d   = stg_rec_q;

        // Running totals including this beat; a new packet starts from zero.
        byte_sum = sat_add(bytes_q, keep_cnt);
        beat_sum = sat_add(beats_q, LEN_W'(1));
        if (state_q == S_IDLE) begin
            byte_sum = sat_add('0, keep_cnt);
            beat_sum = sat_add('0, LEN_W'(1));
        end

        // Flags including this cycle; a stall violation seen while idle
        // belongs to the packet that the stalled word was going to open.
        flags_nxt = flags_q;
        if (state_q == S_IDLE) begin
            flags_nxt = '0;
            flags_nxt[FLG_STALL] = pend_viol_q;
        end
        if (viol) begin
            flags_nxt[FLG_STALL] = 1'b1;
        end
        if (beat) begin
            flags_nxt[FLG_USER] = flags_nxt[FLG_USER] | mon_tuser;
            flags_nxt[FLG_SAT]  = flags_nxt[FLG_SAT] | byte_sum[LEN_W] | beat_sum[LEN_W];
            flags_nxt[FLG_KEEP] = flags_nxt[FLG_KEEP] | keep_err;
        end

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    pend_viol_d = 1'b0;
                    if (mon_tlast) begin
                        stg_valid_d      = 1'b1;
                        stg_rec_d.bytes  = byte_sum[LEN_W-1:0];
                        stg_rec_d.beats  = beat_sum[LEN_W-1:0];
                        stg_rec_d.sop_ts = cyc_q;
                        stg_rec_d.eop_ts = cyc_q;
                        stg_rec_d.flags  = flags_nxt;
                    end else begin
                        state_d  = S_IN_PKT;
                        bytes_d  = byte_sum[LEN_W-1:0];
                        beats_d  = beat_sum[LEN_W-1:0];
                        sop_ts_d = cyc_q;
                        flags_d  = flags_nxt;
                    end
                end else if (viol) begin
                    pend_viol_d = 1'b1;
                end
            end
            S_IN_PKT: begin
                if (beat && mon_tlast) begin
                    stg_valid_d      = 1'b1;
                    stg_rec_d.bytes  = byte_sum[LEN_W-1:0];
                    stg_rec_d.beats  = beat_sum[LEN_W-1:0];
                    stg_rec_d.sop_ts = sop_ts_q;
                    stg_rec_d.eop_ts = cyc_q;
                    stg_rec_d.flags  = flags_nxt;
                    state_d          = S_IDLE;
                    flags_d          = '0;
                end else begin
                    flags_d = flags_nxt;
                    if (beat) begin
                        bytes_d = byte_sum[LEN_W-1:0];
                        beats_d = beat_sum[LEN_W-1:0];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Record FIFO control: a pop frees a slot for a push in the same cycle.
    always_comb begin
        fifo_full = (occ_q == CNT_W'(FIFO_DEPTH));
        fifo_pop  = (occ_q != '0) & rec_ready;
        fifo_push = stg_valid_q & (~fifo_full | fifo_pop);
        fifo_drop = stg_valid_q & fifo_full & ~fifo_pop;
        wr_ptr_d  = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = fifo_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d     = occ_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        drop_d    = drop_q;
        if (fifo_drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // State, accumulator, staging and FIFO-control registers.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            bytes_q     <= '0;
            beats_q     <= '0;
            sop_ts_q    <= '0;
            flags_q     <= '0;
            pend_viol_q <= 1'b0;
            stall_q     <= 1'b0;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
            hold_user_q <= 1'b0;
            stg_valid_q <= 1'b0;
            stg_rec_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            bytes_q     <= bytes_d;
            beats_q     <= beats_d;
            sop_ts_q    <= sop_ts_d;
            flags_q     <= flags_d;
            pend_viol_q <= pend_viol_d;
            stall_q     <= stall_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_last_q <= hold_last_d;
            hold_user_q <= hold_user_d;
            stg_valid_q <= stg_valid_d;
            stg_rec_q   <= stg_rec_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            drop_q      <= drop_d;
        end
    end

    // Record storage; cleared on reset so the outputs read zero afterwards.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_push) begin
            mem_q[wr_ptr_q] <= stg_rec_q;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rec_valid  = (occ_q != '0);
    assign rec_bytes  = head.bytes;
    assign rec_beats  = head.beats;
    assign rec_sop_ts = head.sop_ts;
    assign rec_eop_ts = head.eop_ts;
    assign rec_flags  = head.flags;
    assign drop_cnt   = drop_q;
    assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_hssi_axis_pkt_monitor.sv
// Bench for hssi_axis_pkt_monitor: two instances (16-bit and 4-bit length
// fields) share one stimulus; a packet-level model predicts the record queue.
module tb_hssi_axis_pkt_monitor;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        tvalid, tready, tlast, tuser, rec_ready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    logic        a_valid, b_valid;
    logic [15:0] a_bytes, a_beats, a_drop, b_drop;
    logic [3:0]  b_bytes, b_beats;
    logic [31:0] a_sop, a_eop, a_cyc, b_sop, b_eop, b_cyc;
    logic [3:0]  a_flags, b_flags;

    hssi_axis_pkt_monitor #(.DATA_W(64), .LEN_W(16), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .SoftReset_n(rst_n),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tdata(tdata),
        .mon_tkeep(tkeep), .mon_tlast(tlast), .mon_tuser(tuser),
        .rec_valid(a_valid), .rec_ready(rec_ready), .rec_bytes(a_bytes),
        .rec_beats(a_beats), .rec_sop_ts(a_sop), .rec_eop_ts(a_eop),
        .rec_flags(a_flags), .drop_cnt(a_drop), .cyc_cnt(a_cyc));

    hssi_axis_pkt_monitor #(.DATA_W(64), .LEN_W(4), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .SoftReset_n(rst_n),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tdata(tdata),
        .mon_tkeep(tkeep), .mon_tlast(tlast), .mon_tuser(tuser),
        .rec_valid(b_valid), .rec_ready(rec_ready), .rec_bytes(b_bytes),
        .rec_beats(b_beats), .rec_sop_ts(b_sop), .rec_eop_ts(b_eop),
        .rec_flags(b_flags), .drop_cnt(b_drop), .cyc_cnt(b_cyc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tcyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned bytes;
        int unsigned beats;
        logic [31:0] sop;
        logic [31:0] eop;
        bit user;
        bit viol;
        bit kbad;
    } mrec_t;

    mrec_t       mq[$];
    mrec_t       m_stg, m_cur, m_pop, hd;
    bit          m_stg_v, m_in_pkt, m_pend;
    logic [31:0] m_cyc;
    int unsigned m_drop;
    bit          p_stall, p_last, p_user;
    logic [63:0] p_data;
    logic [7:0]  p_keep;

    function automatic bit last_keep_ok(input logic [7:0] k);
        for (int n = 1; n <= 8; n++) begin
            if (k == 8'((16'd1 << n) - 16'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic longint unsigned satv(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [3:0] exp_flags(input mrec_t r, input int unsigned m);
        return {r.kbad, (r.bytes > m) || (r.beats > m), r.viol, r.user};
    endfunction

    // Model advances once per clock from the stimulus values seen at the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_stg_v = 0; m_in_pkt = 0; m_pend = 0; m_cyc = 0; m_drop = 0;
            p_stall = 0;
        end else begin
            int occ;
            bit pop, v;
            occ = mq.size();
            pop = (occ != 0) && rec_ready;
            if (pop) begin
                m_pop = mq.pop_front();
                $display("TXN pop bytes=%0d beats=%0d sop=%0d eop=%0d", m_pop.bytes, m_pop.beats, m_pop.sop, m_pop.eop);
            end
            if (m_stg_v) begin
                if (occ == DEPTH && !pop) m_drop = (m_drop == 65535) ? 65535 : m_drop + 1;
                else mq.push_back(m_stg);
            end
            m_stg_v = 0;
            v = p_stall && (!tvalid || tdata != p_data || tkeep != p_keep ||
                            tlast != p_last || tuser != p_user);
            m_pend = m_pend | v;
            if (tvalid && tready) begin
                if (!m_in_pkt) begin
                    m_in_pkt = 1;
                    m_cur.bytes = 0; m_cur.beats = 0; m_cur.user = 0; m_cur.kbad = 0;
                    m_cur.sop = m_cyc;
                end
                m_cur.beats++;
                m_cur.bytes += $countones(tkeep);
                m_cur.user |= tuser;
                if (!tlast && tkeep != 8'hFF) m_cur.kbad = 1;
                if (tlast && !last_keep_ok(tkeep)) m_cur.kbad = 1;
                if (tlast) begin
                    m_cur.eop = m_cyc;
                    m_cur.viol = m_pend;
                    m_pend = 0;
                    m_in_pkt = 0;
                    m_stg = m_cur;
                    m_stg_v = 1;
                end
            end
            p_stall = tvalid && !tready;
            p_data = tdata; p_keep = tkeep; p_last = tlast; p_user = tuser;
            m_cyc = m_cyc + 1;
        end
    end

    // Compare both instances against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_a", a_cyc, m_cyc);
            chk("cyc_b", b_cyc, m_cyc);
            chk("drop_a", a_drop, m_drop);
            chk("drop_b", b_drop, m_drop);
            chk("valid_a", a_valid, mq.size() != 0);
            chk("valid_b", b_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                hd = mq[0];
                chk("bytes_a", a_bytes, satv(hd.bytes, 65535));
                chk("beats_a", a_beats, satv(hd.beats, 65535));
                chk("sop_a", a_sop, hd.sop);
                chk("eop_a", a_eop, hd.eop);
                chk("flags_a", a_flags, exp_flags(hd, 65535));
                chk("bytes_b", b_bytes, satv(hd.bytes, 15));
                chk("beats_b", b_beats, satv(hd.beats, 15));
                chk("flags_b", b_flags, exp_flags(hd, 15));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
    endtask

    task automatic drive(input logic v, input logic r, input logic [63:0] d,
                         input logic [7:0] k, input logic l, input logic u);
        tvalid = v; tready = r; tdata = d; tkeep = k; tlast = l; tuser = u;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 64'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;
        tcyc = 0;
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        int n;
        n = 0;
        while (a_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, a_valid, 1'b1);
    endtask

    int          ts[6];
    int          t_single;
    bit          s_stall;
    int unsigned nk;

    initial begin
        rst_n = 1'b0;
        rec_ready = 1'b1;
        idle();
        #1;
        repeat (2) tick();
        // reset state
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_cyc", a_cyc, 0);
        chk("rst_drop", a_drop, 0);
        chk("rst_bytes", a_bytes, 0);
        chk("rst_flags", a_flags, 0);
        do_reset();

        // 3-beat packet starting at cycle 10
        repeat (10) tick();
        drive(1, 1, 64'h1111, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'h2222, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'h3333, 8'h0F, 1, 0); tick();
        idle();
        chk("p1_not_early", a_valid, 1'b0);
        tick();
        chk("p1_valid", a_valid, 1'b1);
        chk("p1_bytes", a_bytes, 20);
        chk("p1_beats", a_beats, 3);
        chk("p1_sop", a_sop, 10);
        chk("p1_eop", a_eop, 12);
        chk("p1_flags", a_flags, 4'b0000);
        chk("p1_bytes_sat", b_bytes, 15);
        chk("p1_beats_sat", b_beats, 3);
        chk("p1_flags_sat", b_flags, 4'b0100);
        tick();

        // single-beat packet with tuser, held by rec_ready=0
        do_reset();
        rec_ready = 1'b0;
        repeat (3) tick();
        t_single = tcyc;
        drive(1, 1, 64'h55, 8'h01, 1, 1); tick();
        idle();
        wait_valid(5, "p2_wait");
        for (int i = 0; i < 3; i++) begin
            chk("p2_beats", a_beats, 1);
            chk("p2_bytes", a_bytes, 1);
            chk("p2_sop", a_sop, t_single);
            chk("p2_eop", a_eop, t_single);
            chk("p2_flags", a_flags, 4'b0001);
            chk("p2_held", a_valid, 1'b1);
            tick();
        end
        rec_ready = 1'b1;
        tick();
        chk("p2_popped", a_valid, 1'b0);

        // six single-beat packets into a 4-deep FIFO with no pops
        do_reset();
        rec_ready = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            ts[i] = tcyc;
            drive(1, 1, 64'(i), 8'hFF, 1, 0);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("p3_drop", a_drop, 2);
        chk("p3_valid", a_valid, 1'b1);
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("p3_order", a_sop, ts[i]);
            tick();
        end
        chk("p3_empty", a_valid, 1'b0);

        // stall with changing data, then a non-last beat with tkeep=7F
        do_reset();
        repeat (2) tick();
        drive(1, 0, 64'hAAAA, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'hBBBB, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'hCCCC, 8'h7F, 0, 0); tick();
        drive(1, 1, 64'hDDDD, 8'hFF, 1, 0); tick();
        idle();
        wait_valid(5, "p4_wait");
        chk("p4_flags", a_flags, 4'b1010);
        chk("p4_bytes", a_bytes, 23);
        chk("p4_beats", a_beats, 3);
        chk("p4_flags_sat", b_flags, 4'b1110);
        tick();

        // reset in the middle of a packet, then a 2-beat packet
        do_reset();
        repeat (2) tick();
        drive(1, 1, 64'h1, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'h2, 8'hFF, 0, 0); tick();
        rst_n = 1'b0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        chk("p6_cyc_restart", a_cyc, 0);
        tick();
        drive(1, 1, 64'h3, 8'hFF, 0, 0); tick();
        drive(1, 1, 64'h4, 8'h0F, 1, 0); tick();
        idle();
        wait_valid(5, "p6_wait");
        chk("p6_beats", a_beats, 2);
        chk("p6_bytes", a_bytes, 12);
        tick();
        chk("p6_only_one", a_valid, 1'b0);

        // randomized traffic
        do_reset();
        s_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                tick(); tick();
                rst_n = 1'b1;
                s_stall = 0;
            end
            rec_ready = ($urandom_range(0, 9) < 6);
            if (s_stall && $urandom_range(0, 9) != 0) begin
                tready = ($urandom_range(0, 2) != 0);
            end else begin
                tvalid = ($urandom_range(0, 3) != 0);
                tready = ($urandom_range(0, 3) != 0);
                tdata  = {$urandom, $urandom};
                tlast  = ($urandom_range(0, 3) == 0);
                tuser  = ($urandom_range(0, 15) == 0);
                if (tlast) begin
                    nk = $urandom_range(1, 8);
                    tkeep = 8'((16'd1 << nk) - 16'd1);
                    if ($urandom_range(0, 7) == 0) tkeep = 8'($urandom);
                end else begin
                    tkeep = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF;
                end
            end
            s_stall = tvalid && !tready;
            tick();
        end
        idle();
        rec_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
